// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: queues 16-bit halfwords from 32-bit fetch words and hands out one
// instruction per handshake. RV32C halfwords are expanded to 32 bits; 32-bit instructions pass through.
module rvc_fetch_aligner #(
    parameter int QDEPTH = 4,
    parameter bit EXT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_rvc,
    output logic        out_illegal
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] instr;
        logic        illegal;
    } expand_t;

    function automatic expand_t expand_rvc(input logic [15:0] c);
        expand_t     r;
        logic        ext;
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] imm6, imm_lw, imm_4spn, imm_16sp, imm_lwsp, imm_swsp;
        logic [12:0] imm_b;
        logic [20:0] imm_j;
        logic [19:0] imm_lui;
        r        = '{instr: 32'h0, illegal: 1'b0};
        ext      = 1'b0;
        rd       = c[11:7];
        rs2      = c[6:2];
        rdp      = {2'b01, c[4:2]};
        rs1p     = {2'b01, c[9:7]};
        imm6     = {{7{c[12]}}, c[6:2]};
        imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
        imm_4spn = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
        imm_16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
        imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
        imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
        imm_b    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        imm_j    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        imm_lui  = {{14{c[12]}}, c[12], c[6:2]};

        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        ext       = 1'b1;
                        r.instr   = {imm_4spn, 5'd2, 3'b000, rdp, OPC_IMM};
                        r.illegal = (imm_4spn == 12'h0);
                    end
                    3'b010:  r.instr = {imm_lw, rs1p, 3'b010, rdp, OPC_LOAD};
                    3'b110:  r.instr = {imm_lw[11:5], rdp, rs1p, 3'b010, imm_lw[4:0], OPC_STORE};
                    default: r.illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: r.instr = {imm6, rd, 3'b000, rd, OPC_IMM};
                    3'b001: r.instr = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], 5'd1, OPC_JAL};
                    3'b010: begin
                        ext     = 1'b1;
                        r.instr = {imm6, 5'd0, 3'b000, rd, OPC_IMM};
                    end
                    3'b011: begin
                        ext = 1'b1;
                        if (rd == 5'd2) begin
                            r.instr   = {imm_16sp, 5'd2, 3'b000, 5'd2, OPC_IMM};
                            r.illegal = (imm_16sp == 12'h0);
                        end else begin
                            r.instr   = {imm_lui, rd, OPC_LUI};
                            r.illegal = ({c[12], c[6:2]} == 6'h0);
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                r.instr   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPC_IMM};
                                r.illegal = c[12];
                            end
                            2'b01: begin
                                r.instr   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_IMM};
                                r.illegal = c[12];
                            end
                            2'b10: r.instr = {imm6, rs1p, 3'b111, rs1p, OPC_IMM};
                            default: begin
                                ext = 1'b1;
                                if (c[12]) begin
                                    r.illegal = 1'b1;
                                end else begin
                                    case (c[6:5])
                                        2'b00:   r.instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                                        2'b01:   r.instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                                        2'b10:   r.instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                                        default: r.instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                                    endcase
                                end
                            end
                        endcase
                    end
                    3'b101: r.instr = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], 5'd0, OPC_JAL};
                    3'b110: r.instr = {imm_b[12], imm_b[10:5], 5'd0, rs1p, 3'b000, imm_b[4:1], imm_b[11], OPC_BRANCH};
                    default: r.instr = {imm_b[12], imm_b[10:5], 5'd0, rs1p, 3'b001, imm_b[4:1], imm_b[11], OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        r.instr   = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_IMM};
                        r.illegal = c[12];
                    end
                    3'b010: begin
                        ext       = 1'b1;
                        r.instr   = {imm_lwsp, 5'd2, 3'b010, rd, OPC_LOAD};
                        r.illegal = (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                r.instr   = {12'h0, rd, 3'b000, 5'd0, OPC_JALR};
                                r.illegal = (rd == 5'd0);
                            end else begin
                                r.instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
                            end
                        end else if (rs2 == 5'd0 && rd == 5'd0) begin
                            ext     = 1'b1;
                            r.instr = 32'h0010_0073;
                        end else if (rs2 == 5'd0) begin
                            r.instr = {12'h0, rd, 3'b000, 5'd1, OPC_JALR};
                        end else begin
                            r.instr = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
                        end
                    end
                    3'b110: begin
                        ext     = 1'b1;
                        r.instr = {imm_swsp[11:5], rs2, 5'd2, 3'b010, imm_swsp[4:0], OPC_STORE};
                    end
                    default: r.illegal = 1'b1;
                endcase
            end
            default: r.illegal = 1'b1;
        endcase

        if (ext && !EXT_EN) r.illegal = 1'b1;
        if (r.illegal) r.instr = 32'h0;
        return r;
    endfunction

    logic [15:0]   mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_nxt, wr_nxt;
    logic [CW-1:0] count_q, count_d, n_push, n_pop;
    logic [31:0]   pc_q, pc_d;
    logic          drop_low_q, drop_low_d;
    logic [15:0]   head_hw, next_hw;
    logic          is_32, have_instr, do_push, do_pop;
    expand_t       exp_w;
    logic          unused_flush_pc0;

    assign unused_flush_pc0 = flush_pc[0];

    assign rd_nxt  = rd_ptr_q + PW'(1);
    assign wr_nxt  = wr_ptr_q + PW'(1);
    assign head_hw = mem_q[rd_ptr_q];
    assign next_hw = mem_q[rd_nxt];
    assign is_32   = (head_hw[1:0] == 2'b11);
    assign exp_w   = expand_rvc(head_hw);

    assign have_instr  = is_32 ? (count_q >= CW'(2)) : (count_q != '0);
    assign fetch_ready = rst_n && (count_q <= CW'(QDEPTH - 2));
    assign out_valid   = rst_n && have_instr;
    assign out_instr   = is_32 ? {next_hw, head_hw} : exp_w.instr;
    assign out_pc      = pc_q;
    assign out_is_rvc  = out_valid && !is_32;
    assign out_illegal = out_valid && !is_32 && exp_w.illegal;

    assign do_push = fetch_valid && fetch_ready && !flush;
    assign do_pop  = out_valid && out_ready && !flush;
    assign n_push  = do_push ? (drop_low_q ? CW'(1) : CW'(2)) : '0;
    assign n_pop   = do_pop ? (is_32 ? CW'(2) : CW'(1)) : '0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_d       = pc_q;
        drop_low_d = drop_low_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pc_d       = {flush_pc[31:1], 1'b0};
            drop_low_d = flush_pc[1];
        end else begin
            count_d  = count_q + n_push - n_pop;
            wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
            rd_ptr_d = rd_ptr_q + n_pop[PW-1:0];
            if (do_pop) pc_d = pc_q + (is_32 ? 32'd4 : 32'd2);
            if (do_push) drop_low_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_q       <= '0;
            drop_low_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            drop_low_q <= drop_low_d;
        end
    end

    // NOTE: queue storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (drop_low_q) begin
                mem_q[wr_ptr_q] <= fetch_data[31:16];
            end else begin
                mem_q[wr_ptr_q] <= fetch_data[15:0];
                mem_q[wr_nxt]   <= fetch_data[31:16];
            end
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed self-checking bench for rvc_fetch_aligner: alignment, straddling, flush,
// backpressure, reset priority and a spread of RVC expansions.
module tb_rvc_fetch_aligner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_rvc;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    rvc_fetch_aligner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_data (fetch_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_is_rvc (out_is_rvc),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input string tag, input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_data  = w;
        while (!fetch_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_push_timeout"}, 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1 fetch_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                             input logic rvc, input logic ill);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, ins);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_rvc"}, 32'(out_is_rvc), 32'(rvc));
        check({tag, "_ill"}, 32'(out_illegal), 32'(ill));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        out_ready   = 1'b0;

        // Held in reset: all handshake/status outputs low.
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_is_rvc", 32'(out_is_rvc), 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pc", out_pc, 32'h0);
        check("post_rst_ready", 32'(fetch_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Two C.LI in one word.
        push("two_rvc", 32'h4501_4505);
        pop_check("li1", 32'h0010_0513, 32'h0, 1'b1, 1'b0);
        pop_check("li0", 32'h0000_0513, 32'h2, 1'b1, 1'b0);
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_pc", out_pc, 32'h4);

        // Straddling 32-bit instruction, second word pushed while the first RVC pops.
        do_reset();
        push("strad_a", 32'h0513_4505);
        @(negedge clk);
        check("strad_rvc_instr", out_instr, 32'h0010_0513);
        check("strad_rvc_pc", out_pc, 32'h0);
        check("strad_rvc_flag", 32'(out_is_rvc), 32'd1);
        fetch_valid = 1'b1;
        fetch_data  = 32'h0000_0010;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        out_ready   = 1'b0;
        pop_check("strad32", 32'h0010_0513, 32'h2, 1'b0, 1'b0);
        pop_check("strad_tail", 32'h0, 32'h6, 1'b1, 1'b1);

        // C.ADD then an all-zero halfword.
        do_reset();
        push("add", 32'h0000_952E);
        pop_check("c_add", 32'h00B5_0533, 32'h0, 1'b1, 1'b0);
        pop_check("zero_hw", 32'h0, 32'h2, 1'b1, 1'b1);

        // Flush discards queued data and same-cycle handshakes, then drops the low half.
        do_reset();
        push("pre_flush", 32'h4501_4505);
        @(negedge clk);
        flush       = 1'b1;
        flush_pc    = 32'h0000_0102;
        fetch_valid = 1'b1;
        fetch_data  = 32'h1234_5678;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc", out_pc, 32'h102);
        push("drop_low", 32'h4505_FFFF);
        pop_check("after_flush", 32'h0010_0513, 32'h102, 1'b1, 1'b0);
        @(negedge clk);
        check("after_flush_empty", 32'(out_valid), 32'd0);
        check("after_flush_pc", out_pc, 32'h104);

        // Backpressure with a full 4-entry queue.
        do_reset();
        push("fill_a", 32'h4505_4505);
        push("fill_b", 32'h4501_4501);
        @(negedge clk);
        check("full_ready", 32'(fetch_ready), 32'd0);
        pop_check("bp_pop1", 32'h0010_0513, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("three_ready", 32'(fetch_ready), 32'd0);
        pop_check("bp_pop2", 32'h0010_0513, 32'h2, 1'b1, 1'b0);
        @(negedge clk);
        check("two_ready", 32'(fetch_ready), 32'd1);

        // Reset mid-instruction with 3 halfwords queued beats flush and handshakes.
        pop_check("bp_pop3", 32'h0000_0513, 32'h4, 1'b1, 1'b0);
        push("three", 32'h0513_4505);
        @(negedge clk);
        rst_n       = 1'b0;
        flush       = 1'b1;
        flush_pc    = 32'h0000_0200;
        fetch_valid = 1'b1;
        fetch_data  = 32'h4505_4505;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_pc", out_pc, 32'h0);
        check("rst_mid_ready", 32'(fetch_ready), 32'd1);
        push("post_mid", 32'h4501_4501);
        pop_check("post_mid_head", 32'h0000_0513, 32'h0, 1'b1, 1'b0);

        // Assorted expansions and illegal encodings.
        do_reset();
        push("dec_a", 32'hBFFD_40C0);
        pop_check("c_lw", 32'h0044_A403, 32'h0, 1'b1, 1'b0);
        pop_check("c_j", 32'hFFFF_F06F, 32'h2, 1'b1, 1'b0);
        push("dec_b", 32'h4002_1506);
        pop_check("slli_sh5", 32'h0, 32'h4, 1'b1, 1'b1);
        pop_check("lwsp_rd0", 32'h0, 32'h6, 1'b1, 1'b1);
        push("dec_c", 32'hC401_8002);
        pop_check("jr_rs0", 32'h0, 32'h8, 1'b1, 1'b1);
        pop_check("c_beqz", 32'h0004_0463, 32'hA, 1'b1, 1'b0);
        push("dec_d", 32'h157D_840D);
        pop_check("c_srai", 32'h4034_5413, 32'hC, 1'b1, 1'b0);
        pop_check("c_addi_neg", 32'hFFF5_0513, 32'hE, 1'b1, 1'b0);
        push("dec_e", 32'h4505_0004);
        pop_check("a4spn_zero", 32'h0, 32'h10, 1'b1, 1'b1);
        pop_check("c_li_last", 32'h0010_0513, 32'h12, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rvc_fetch_aligner.md
RVC_FETCH_ALIGNER -- requirements
Module: rvc_fetch_aligner

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, meaning halfword queue depth; power of two, >=4.
REQ-002 SHALL have parameter EXT_EN, default 1, meaning 1 = full RV32C decode, 0 = base subset only.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port flush  input  1  discard queue and restart at flush_pc.
REQ-006 SHALL have port flush_pc  input  32  restart address, bit0 ignored.
REQ-007 SHALL have port fetch_valid  input  1  fetch word offered.
REQ-008 SHALL have port fetch_ready  output  1  word accepted when valid&&ready.
REQ-009 SHALL have port fetch_data  input  32  aligned word; [15:0] is the lower-address halfword.
REQ-010 SHALL have port out_valid  output  1  expanded instruction available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port out_instr  output  32  expanded 32-bit instruction.
REQ-013 SHALL have port out_pc  output  32  address of out_instr.
REQ-014 SHALL have port out_is_rvc  output  1  source was 16-bit.
REQ-015 SHALL have port out_illegal  output  1  source halfword is illegal or reserved.

Function
REQ-016 SHALL store halfwords in a circular queue of QDEPTH entries with wrapping rd/wr pointers and a count 0..QDEPTH.
REQ-017 SHALL drive fetch_ready = rst_n && (QDEPTH-count >= 2), using count before any same-cycle pop.
REQ-018 SHALL push 2 halfwords per fetch handshake, except it SHALL push only fetch_data[31:16] when drop_low is set, then clear drop_low.
REQ-019 SHALL treat head[1:0]!=2'b11 as a 16-bit instruction, valid when count>=1.
REQ-020 SHALL treat head[1:0]==2'b11 as a 32-bit instruction, valid when count>=2, formed as {next,head}.
REQ-021 SHALL present out_* combinationally from queue state, giving 1-cycle latency from fetch handshake to out_valid.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL, on out_valid&&out_ready, pop 1 or 2 halfwords and advance out_pc by 2 or 4; push and pop in the same cycle are both honoured.
REQ-024 SHALL, on flush, clear count and pointers, set out_pc={flush_pc[31:1],0}, and set drop_low=flush_pc[1]; same-cycle fetch and out handshakes are ignored.
REQ-025 SHALL sign-extend all RVC immediates per RV32C; scaled offsets SHALL be zero-extended (LW/SW/LWSP/SWSP/ADDI4SPN).
REQ-026 SHALL expand the base subset in both modes: C.ADDI/NOP, C.LW, C.SW, C.ANDI, C.SRLI, C.SRAI, C.SLLI, C.BEQZ, C.BNEZ, C.J, C.JAL, C.JR, C.JALR, C.MV, C.ADD.
REQ-027 SHALL, with EXT_EN=1, additionally expand C.ADDI4SPN, C.LI, C.LUI, C.ADDI16SP, C.SUB, C.XOR, C.OR, C.AND, C.LWSP, C.SWSP, C.EBREAK.
REQ-028 SHALL flag the following as out_illegal=1 with out_instr=32'h0: halfword 16'h0000; shamt[5]=1; C.ADDI4SPN imm=0; C.LUI/ADDI16SP imm=0; C.JR rs1=0; C.LWSP rd=0; any encoding not enabled.
REQ-029 SHALL pass 32-bit instructions unchanged with out_is_rvc=0 and out_illegal=0.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, clear count, pointers and drop_low, and set out_pc=0.
REQ-031 SHALL hold out_valid=0, fetch_ready=0, out_is_rvc=0 and out_illegal=0 while rst_n=0.
REQ-032 SHALL give reset priority over flush and over all handshakes, including mid-instruction.

Verification
REQ-033 Reset; push 32'h4501_4505; out_ready=1 -> out_instr 32'h00100513 @pc 0, then 32'h00000513 @pc 2, with is_rvc=1 for both.
REQ-034 Push 32'h0513_4505 then 32'h0000_0010 -> 32'h00100513 @pc 0 (rvc), then straddling 32'h00100513 @pc 2 with is_rvc=0; next pc 6.
REQ-035 Push 32'h0000_952E -> 32'h00B50533 (add a0,a0,a1); the upper halfword 16'h0000 -> out_illegal=1 @pc 2.
REQ-036 flush with flush_pc=32'h102, then push 32'h4505_FFFF -> low half dropped; 32'h00100513 @pc 32'h102.
REQ-037 QDEPTH=4, out_ready=0: two pushes accepted, then fetch_ready=0; one 16-bit pop frees one entry and fetch_ready stays 0; a second pop raises fetch_ready=1.
REQ-038 rst_n=0 for one cycle with 3 halfwords queued -> next cycle out_valid=0, count 0, out_pc 0.
